if_fetch_stage: RTL and testbench

//  Instruction-fetch stage between the program counter and the IF/ID boundary.
//  - Issues req/ack reads to instruction memory.
//  - Tells the PC when to load its next value.
//  - Buffers one returned word while decode is stalled.
//  - Drives the IF/ID register: valid, pc, instr.
//  - Handles branch flush, including discarding a response that is still in flight.

---
 rtl/if_fetch_stage.sv | 192 +++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction fetch between the PC and the IF/ID register. Issues
//            req/ack reads to instruction memory and holds one word in a skid
//            buffer while decode stalls. A branch flush discards any response
//            that is still in flight.
//            Optional: define FETCH_PERF_CNT_EN to add o_wait_cnt/o_drop_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] i_pc_next,
    output logic            o_pc_advance,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [31:0]     i_imem_rdata,
    input  logic            i_stall,
    input  logic            i_flush,
    output logic            o_ifid_valid,
    output logic [XLEN-1:0] o_ifid_pc,
    output logic [31:0]     o_ifid_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     o_wait_cnt,
    output logic [15:0]     o_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_req;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_redirect;
    logic [XLEN-1:0] r_skid_pc;
    logic [31:0]     r_skid_instr;
    logic            r_ifid_valid;
    logic [XLEN-1:0] r_ifid_pc;
    logic [31:0]     r_ifid_instr;

    logic            w_fetch_ack;

    // Only a live (non-dropped) fetch hands its address on to the PC.
    assign w_fetch_ack  = (r_state == S_FETCH) && i_imem_ack;
    assign o_pc_advance = i_flush || w_fetch_ack;

    assign o_imem_req   = r_req;
    assign o_imem_addr  = r_addr;
    assign o_ifid_valid = r_ifid_valid;
    assign o_ifid_pc    = r_ifid_pc;
    assign o_ifid_instr = r_ifid_instr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_addr       <= RESET_PC;
            r_redirect   <= RESET_PC;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
        end else if (i_flush) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            case (r_state)
                S_IDLE: begin
                    r_addr  <= i_pc_next;
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    // The address must not change under an open request.
                    if (i_imem_ack) begin
                        r_addr <= i_pc_next;
                    end else begin
                        r_redirect <= i_pc_next;
                        r_state    <= S_DROP;
                    end
                end
                S_FULL: begin
                    r_addr  <= i_pc_next;
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_DROP: begin
                    if (i_imem_ack) begin
                        r_addr  <= i_pc_next;
                        r_state <= S_FETCH;
                    end else begin
                        r_redirect <= i_pc_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    if (i_imem_ack) begin
                        r_addr <= i_pc_next;
                        if (i_stall) begin
                            r_skid_pc    <= r_addr;
                            r_skid_instr <= i_imem_rdata;
                            r_state      <= S_FULL;
                            r_req        <= 1'b0;
                        end else begin
                            r_ifid_valid <= 1'b1;
                            r_ifid_pc    <= r_addr;
                            r_ifid_instr <= i_imem_rdata;
                        end
                    end else if (!i_stall) begin
                        // Decode consumed the last word and nothing new arrived.
                        r_ifid_valid <= 1'b0;
                        r_ifid_pc    <= '0;
                        r_ifid_instr <= NOP_INSTR;
                    end
                end
                S_FULL: begin
                    if (!i_stall) begin
                        r_ifid_valid <= 1'b1;
                        r_ifid_pc    <= r_skid_pc;
                        r_ifid_instr <= r_skid_instr;
                        r_state      <= S_FETCH;
                        r_req        <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (i_imem_ack) begin
                        r_addr  <= r_redirect;
                        r_state <= S_FETCH;
                    end
                    if (!i_stall) begin
                        r_ifid_valid <= 1'b0;
                        r_ifid_pc    <= '0;
                        r_ifid_instr <= NOP_INSTR;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        w_discard;
    logic [31:0] r_wait_cnt;
    logic [15:0] r_drop_cnt;

    assign w_discard  = r_req && i_imem_ack && (i_flush || (r_state == S_DROP));
    assign o_wait_cnt = r_wait_cnt;
    assign o_drop_cnt = r_drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (r_req && !i_imem_ack) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
            if (w_discard) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// Self-checking bench for if_fetch_stage: directed vector table, a reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_pc_next;
    logic        o_pc_advance;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_flush;
    logic        o_ifid_valid;
    logic [31:0] o_ifid_pc;
    logic [31:0] o_ifid_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_wait_cnt;
    logic [15:0] o_drop_cnt;
`endif

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_pc_next    (i_pc_next),
        .o_pc_advance (o_pc_advance),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ack   (i_imem_ack),
        .i_imem_rdata (i_imem_rdata),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .o_ifid_valid (o_ifid_valid),
        .o_ifid_pc    (o_ifid_pc),
        .o_ifid_instr (o_ifid_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_wait_cnt   (o_wait_cnt),
        .o_drop_cnt   (o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        ack;
        logic [31:0] pc_next;
        logic [31:0] rdata;
        logic        e_adv;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    function automatic vec_t mkv(input logic st, input logic fl, input logic ak,
                                 input logic [31:0] pn, input logic [31:0] rd,
                                 input logic ea, input logic er, input logic [31:0] ead,
                                 input logic ev, input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.stall = st; v.flush = fl; v.ack = ak; v.pc_next = pn; v.rdata = rd;
        v.e_adv = ea; v.e_req = er; v.e_addr = ead;
        v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    // ---------------- reference model ----------------
    logic        m_started, m_req, m_drop, m_valid;
    logic [31:0] m_addr, m_redirect, m_pc, m_instr;
    logic [63:0] m_skid [$];
    int unsigned m_wait, m_dropc;

    task automatic model_init();
        m_started = 1'b0; m_req = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
        m_addr = 32'h0; m_redirect = 32'h0; m_pc = 32'h0; m_instr = NOP;
        m_skid.delete();
        m_wait = 0; m_dropc = 0;
    endtask

    task automatic bubble();
        m_valid = 1'b0; m_pc = 32'h0; m_instr = NOP;
    endtask

    task automatic model_step(input logic fl, input logic st, input logic ak,
                              input logic [31:0] rd, input logic [31:0] pn);
        logic [31:0] cur;
        logic [63:0] e;
        cur = m_addr;
        if (m_req && !ak) m_wait++;
        if (m_req && ak && (fl || m_drop)) m_dropc++;
        if (fl) begin
            bubble();
            m_skid.delete();
        end
        if (!m_started) begin
            m_started = 1'b1;
            m_req = 1'b1;
            if (fl) m_addr = pn;
        end else if (fl) begin
            if (!m_req) begin
                m_addr = pn; m_req = 1'b1;
            end else if (ak) begin
                m_addr = pn; m_drop = 1'b0;
            end else begin
                m_redirect = pn; m_drop = 1'b1;
            end
        end else if (m_req) begin
            if (ak && !m_drop) begin
                m_addr = pn;
                if (st) begin
                    m_skid.push_back({cur, rd});
                    m_req = 1'b0;
                end else begin
                    m_valid = 1'b1; m_pc = cur; m_instr = rd;
                end
            end else begin
                if (ak) begin
                    m_drop = 1'b0; m_addr = m_redirect;
                end
                if (!st) bubble();
            end
        end else if (!st && m_skid.size() > 0) begin
            e = m_skid.pop_front();
            m_valid = 1'b1; m_pc = e[63:32]; m_instr = e[31:0];
            m_req = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_flush = 1'b0; i_stall = 1'b0; i_imem_ack = 1'b0;
        i_imem_rdata = 32'h0; i_pc_next = 32'h4;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        model_init();
    endtask

    initial begin
        logic        fl, st, ak, e_adv;
        logic [31:0] rd, pn, b_pc;

        vt[0]  = mkv(0,0,0, 32'h04, 32'h0,          0,0,32'h00, 0,32'h00,NOP);
        vt[1]  = mkv(0,0,1, 32'h04, 32'hC0DE0000,   1,1,32'h00, 1,32'h00,32'hC0DE0000);
        vt[2]  = mkv(0,0,1, 32'h08, 32'hC0DE0004,   1,1,32'h04, 1,32'h04,32'hC0DE0004);
        vt[3]  = mkv(1,0,1, 32'h0C, 32'hC0DE0008,   1,1,32'h08, 1,32'h04,32'hC0DE0004);
        vt[4]  = mkv(1,0,1, 32'h10, 32'hDEADBEEF,   0,0,32'h00, 1,32'h04,32'hC0DE0004);
        vt[5]  = mkv(0,0,0, 32'h10, 32'h0,          0,0,32'h00, 1,32'h08,32'hC0DE0008);
        vt[6]  = mkv(0,0,1, 32'h10, 32'hC0DE000C,   1,1,32'h0C, 1,32'h0C,32'hC0DE000C);
        vt[7]  = mkv(0,0,0, 32'h14, 32'h0,          0,1,32'h10, 0,32'h00,NOP);
        vt[8]  = mkv(0,0,0, 32'h14, 32'h0,          0,1,32'h10, 0,32'h00,NOP);
        vt[9]  = mkv(0,0,0, 32'h14, 32'h0,          0,1,32'h10, 0,32'h00,NOP);
        vt[10] = mkv(0,0,1, 32'h14, 32'hC0DE0010,   1,1,32'h10, 1,32'h10,32'hC0DE0010);
        vt[11] = mkv(0,0,1, 32'h18, 32'hC0DE0014,   1,1,32'h14, 1,32'h14,32'hC0DE0014);
        vt[12] = mkv(0,0,1, 32'h1C, 32'hC0DE0018,   1,1,32'h18, 1,32'h18,32'hC0DE0018);
        vt[13] = mkv(0,0,1, 32'h20, 32'hC0DE001C,   1,1,32'h1C, 1,32'h1C,32'hC0DE001C);
        vt[14] = mkv(0,0,0, 32'h24, 32'h0,          0,1,32'h20, 0,32'h00,NOP);
        vt[15] = mkv(0,1,0, 32'h40, 32'h0,          1,1,32'h20, 0,32'h00,NOP);
        vt[16] = mkv(0,0,0, 32'h44, 32'h0,          0,1,32'h20, 0,32'h00,NOP);
        vt[17] = mkv(0,0,1, 32'h44, 32'hBADBAD20,   0,1,32'h20, 0,32'h00,NOP);
        vt[18] = mkv(0,0,1, 32'h44, 32'hC0DE0040,   1,1,32'h40, 1,32'h40,32'hC0DE0040);
        vt[19] = mkv(1,1,1, 32'h80, 32'hC0DE0044,   1,1,32'h44, 0,32'h00,NOP);
        vt[20] = mkv(0,0,1, 32'h84, 32'hC0DE0080,   1,1,32'h80, 1,32'h80,32'hC0DE0080);

        reset = 1'b1;
        i_flush = 1'b0; i_stall = 1'b0; i_imem_ack = 1'b0;
        i_imem_rdata = 32'h0; i_pc_next = 32'h0;
        #1;
        chk("rst_req",   32'(o_imem_req),   32'h0);
        chk("rst_valid", 32'(o_ifid_valid), 32'h0);
        chk("rst_pc",    o_ifid_pc,         32'h0);
        chk("rst_instr", o_ifid_instr,      NOP);
        chk("rst_addr",  o_imem_addr,       32'h0);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            i_stall = vt[i].stall; i_flush = vt[i].flush; i_imem_ack = vt[i].ack;
            i_pc_next = vt[i].pc_next; i_imem_rdata = vt[i].rdata;
            #1;
            chk($sformatf("tab%0d_adv", i), 32'(o_pc_advance), 32'(vt[i].e_adv));
            chk($sformatf("tab%0d_req", i), 32'(o_imem_req),   32'(vt[i].e_req));
            if (vt[i].e_req) chk($sformatf("tab%0d_addr", i), o_imem_addr, vt[i].e_addr);
            @(posedge clk);
            #1;
            chk($sformatf("tab%0d_valid", i), 32'(o_ifid_valid), 32'(vt[i].e_valid));
            chk($sformatf("tab%0d_instr", i), o_ifid_instr, vt[i].e_instr);
            if (vt[i].e_valid || vt[i].flush)
                chk($sformatf("tab%0d_pc", i), o_ifid_pc, vt[i].e_pc);
        end

        // Reset asserted mid-request, with a stray ack around it.
        @(negedge clk);
        i_flush = 1'b0; i_stall = 1'b0; i_imem_ack = 1'b0; i_pc_next = 32'h88;
        #1 chk("midrst_pre_req", 32'(o_imem_req), 32'h1);
        chk("midrst_pre_addr", o_imem_addr, 32'h84);
        #1 reset = 1'b1;
        #1;
        chk("midrst_req",   32'(o_imem_req),   32'h0);
        chk("midrst_valid", 32'(o_ifid_valid), 32'h0);
        chk("midrst_instr", o_ifid_instr,      NOP);
        i_imem_ack = 1'b1; i_imem_rdata = 32'hBAADF00D;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("postrst_idle_req", 32'(o_imem_req),   32'h0);
        chk("postrst_idle_adv", 32'(o_pc_advance), 32'h0);
        @(posedge clk);
        #1;
        chk("postrst_valid", 32'(o_ifid_valid), 32'h0);
        @(negedge clk);
        i_imem_ack = 1'b0;
        #1;
        chk("postrst_req",  32'(o_imem_req), 32'h1);
        chk("postrst_addr", o_imem_addr,     32'h0);

        // Randomized traffic against the reference model.
        do_reset();
        b_pc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            fl = ($urandom_range(0, 99) < 8);
            st = ($urandom_range(0, 99) < 30);
            ak = ($urandom_range(0, 99) < 55);
            rd = $urandom;
            pn = fl ? ($urandom_range(0, 1023) << 2) : (b_pc + 32'd4);
            i_flush = fl; i_stall = st; i_imem_ack = ak;
            i_imem_rdata = rd; i_pc_next = pn;
            #1;
            e_adv = fl || (m_req && ak && !m_drop);
            chk("rnd_adv",   32'(o_pc_advance), 32'(e_adv));
            chk("rnd_req",   32'(o_imem_req),   32'(m_req));
            if (m_req) chk("rnd_addr", o_imem_addr, m_addr);
            chk("rnd_valid", 32'(o_ifid_valid), 32'(m_valid));
            chk("rnd_instr", o_ifid_instr,      m_instr);
            if (m_valid) chk("rnd_pc", o_ifid_pc, m_pc);
`ifdef FETCH_PERF_CNT_EN
            chk("rnd_wait_cnt", o_wait_cnt, m_wait);
            chk("rnd_drop_cnt", 32'(o_drop_cnt), 32'(m_dropc[15:0]));
`endif
            if (e_adv) b_pc = pn;
            model_step(fl, st, ak, rd, pn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
